factory_test_sequencer: RTL and testbench



---
 rtl/factory_test_pkg.sv | 32 +++
 rtl/ft_lfsr8.sv | 24 ++
 rtl/factory_test_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_factory_test_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/factory_test_pkg.sv
// factory_test_pkg: shared types and constants for the factory-test sequencer.
// Holds the FSM state enum, phase codes reported on the phase output, and the
// LFSR taps and seed used to generate the loopback pattern.
package factory_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN3V3,
    GAP1,
    EN1V8,
    GAP2,
    LOOP,
    DRAIN,
    DONE
  } ft_state_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_3V3  = 2'd1,
    PH_1V8  = 2'd2,
    PH_LOOP = 2'd3
  } ft_phase_t;

  // x^8+x^6+x^5+x^4+1, taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ft_lfsr8.sv
// ft_lfsr8: 8-bit Fibonacci LFSR with synchronous load-to-seed and step.
// Load has priority over step; the register holds when neither is asserted.
module ft_lfsr8
  import factory_test_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  // Pattern register: seed on load, advance one value on step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/factory_test_sequencer.sv
// factory_test_sequencer: sequences the bias cell's active-low 3.3 V / 1.8 V
// enables with break-before-make gaps, then drives an LFSR pattern over the
// uio loopback and counts mismatches against the synchronized return path.
// Optional macro FT_ERRCAP_EN adds err_idx/err_data first-mismatch capture.
module factory_test_sequencer
  import factory_test_pkg::*;
#(
  parameter int DWELL_W     = 16,
  parameter int DWELL_CYC   = 1000,
  parameter int GAP_CYC     = 16,
  parameter int LOOP_LEN    = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  output logic       ena_3v3_n,
  output logic       ena_1v8_n,
  output logic [7:0] pat_out,
  output logic [7:0] pat_oe,
  input  logic [7:0] pat_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [1:0] phase
`ifdef FT_ERRCAP_EN
  ,
  output logic [7:0] err_idx,
  output logic [7:0] err_data
`endif
);

  localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL_CYC - 1);
  localparam logic [DWELL_W-1:0] GAP_LD   = DWELL_W'(GAP_CYC - 1);
  localparam logic [DWELL_W-1:0] LOOP_LD  = DWELL_W'(LOOP_LEN - 1);
  localparam logic [DWELL_W-1:0] DRAIN_LD = DWELL_W'(SYNC_STAGES);

  ft_state_t            state;
  logic [DWELL_W-1:0]   cnt;
  logic [SYNC_STAGES-1:0] start_sync;
  logic                 start_q;
  logic [7:0]           pat_sync [SYNC_STAGES];
  logic [7:0]           exp_q    [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;
  logic                 launch;
  logic                 cnt_zero;
  logic                 lfsr_load;
  logic                 lfsr_step;
  logic                 cmp_vld;
  logic                 mismatch;

  assign cnt_zero  = (cnt == '0);
  assign launch    = ena && start_sync[SYNC_STAGES-1] && !start_q &&
                     ((state == IDLE) || (state == DONE));
  assign lfsr_load = ena && (state == GAP2) && cnt_zero;
  assign lfsr_step = (state == LOOP) && !cnt_zero;
  assign cmp_vld   = vld_q[SYNC_STAGES-1];
  assign mismatch  = cmp_vld && (pat_sync[SYNC_STAGES-1] != exp_q[SYNC_STAGES-1]);

  ft_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (pat_out)
  );

  // Start synchronizer plus one flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      start_q    <= 1'b0;
    end else begin
      start_sync[0] <= start;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) start_sync[i] <= start_sync[i-1];
      start_q <= start_sync[SYNC_STAGES-1];
    end
  end

  // The expected line runs through the same depth as the pat_in synchronizer,
  // so both ends line up; the registered count adds the final cycle of delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        pat_sync[i] <= '0;
        exp_q[i]    <= '0;
      end
      vld_q <= '0;
    end else begin
      pat_sync[0] <= pat_in;
      exp_q[0]    <= pat_out;
      vld_q[0]    <= ena && (state == LOOP);
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        pat_sync[i] <= pat_sync[i-1];
        exp_q[i]    <= exp_q[i-1];
        vld_q[i]    <= ena && vld_q[i-1];
      end
    end
  end

  // Saturating mismatch counter, cleared by launch and kept across abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (launch) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != 4'hF)) begin
      err_cnt <= err_cnt + 4'd1;
    end
  end

`ifdef FT_ERRCAP_EN
  logic [7:0] cmp_idx;

  // Index every compared sample and latch the first failing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_idx  <= '0;
      err_idx  <= '1;
      err_data <= '0;
    end else if (launch) begin
      cmp_idx  <= '0;
      err_idx  <= '1;
      err_data <= '0;
    end else if (cmp_vld) begin
      cmp_idx <= cmp_idx + 8'd1;
      if (mismatch && (err_idx == 8'hFF)) begin
        err_idx  <= cmp_idx;
        err_data <= pat_sync[SYNC_STAGES-1];
      end
    end
  end
`endif

  // Sequencer FSM; every output is registered on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ena_3v3_n <= 1'b1;
      ena_1v8_n <= 1'b1;
      pat_oe    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      phase     <= PH_IDLE;
    end else if (!ena) begin
      state     <= IDLE;
      ena_3v3_n <= 1'b1;
      ena_1v8_n <= 1'b1;
      pat_oe    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      phase     <= PH_IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state     <= EN3V3;
            cnt       <= DWELL_LD;
            ena_3v3_n <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            phase     <= PH_3V3;
          end
        end
        EN3V3: begin
          if (cnt_zero) begin
            state     <= GAP1;
            cnt       <= GAP_LD;
            ena_3v3_n <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        GAP1: begin
          if (cnt_zero) begin
            state     <= EN1V8;
            cnt       <= DWELL_LD;
            ena_1v8_n <= 1'b0;
            phase     <= PH_1V8;
          end else cnt <= cnt - 1'b1;
        end
        EN1V8: begin
          if (cnt_zero) begin
            state     <= GAP2;
            cnt       <= GAP_LD;
            ena_1v8_n <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        GAP2: begin
          if (cnt_zero) begin
            state  <= LOOP;
            cnt    <= LOOP_LD;
            pat_oe <= '1;
            phase  <= PH_LOOP;
          end else cnt <= cnt - 1'b1;
        end
        LOOP: begin
          if (cnt_zero) begin
            state <= DRAIN;
            cnt   <= DRAIN_LD;
          end else cnt <= cnt - 1'b1;
        end
        DRAIN: begin
          if (cnt_zero) begin
            state  <= DONE;
            pat_oe <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (err_cnt == 4'd0);
            phase  <= PH_IDLE;
          end else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factory_test_sequencer.sv
// tb_factory_test_sequencer: randomized self-checking bench. A high-level
// model (pattern list plus per-pattern corruption table) predicts error
// count, pass and first-error capture; traces check timing and patterns.
module tb_factory_test_sequencer;

  localparam int LEN = 16;
  localparam int SS  = 2;
  localparam int DW  = 8;
  localparam int GP  = 2;

  logic       clk = 1'b0;
  logic       rst_n, ena, start;
  logic       ena_3v3_n, ena_1v8_n, busy, done, pass;
  logic [7:0] pat_out, pat_oe, pat_in;
  logic [3:0] err_cnt;
  logic [1:0] phase;
`ifdef FT_ERRCAP_EN
  logic [7:0] err_idx, err_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] and_mask = 8'hFF;
  logic [7:0] junk     = 8'h00;
  logic [7:0] xor_by_val [256];
  logic [7:0] seq [LEN];

  always #5 clk = ~clk;

  // Loopback with optional stuck bits and per-pattern corruption.
  assign pat_in = (pat_oe == 8'hFF) ? ((pat_out & and_mask) ^ xor_by_val[pat_out]) : junk;

  factory_test_sequencer #(
    .DWELL_W     (16),
    .DWELL_CYC   (DW),
    .GAP_CYC     (GP),
    .LOOP_LEN    (LEN),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .ena_3v3_n (ena_3v3_n),
    .ena_1v8_n (ena_1v8_n),
    .pat_out   (pat_out),
    .pat_oe    (pat_oe),
    .pat_in    (pat_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .phase     (phase)
`ifdef FT_ERRCAP_EN
    ,
    .err_idx   (err_idx),
    .err_data  (err_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Break-before-make must hold in every sampled cycle.
  always @(negedge clk) begin
    check("never_both_low", {31'b0, (!ena_3v3_n && !ena_1v8_n)}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic clear_corrupt();
    for (int i = 0; i < 256; i++) xor_by_val[i] = 8'h00;
    and_mask = 8'hFF;
  endtask

  task automatic run_seq(input string tag, input bit restart_mid);
    int cyc = 0, n3 = 0, n18 = 0, noe = 0, phase_bad = 0;
    int first3 = -1, last3 = -1, first18 = -1, last18 = -1, firstoe = -1;
    bit seen_busy = 1'b0;
    logic [7:0] pats [$];
    int exp_errs = 0, exp_idx = 255;
    logic [7:0] exp_data = 8'h00, obs, want;

    for (int i = 0; i < LEN; i++) begin
      obs = (seq[i] & and_mask) ^ xor_by_val[seq[i]];
      if (obs != seq[i]) begin
        exp_errs++;
        if (exp_idx == 255) begin
          exp_idx  = i;
          exp_data = obs;
        end
      end
    end
    junk  = 8'($urandom);
    start = 1'b1;
    while (!(seen_busy && done) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) start = 1'b0;
      if (busy) seen_busy = 1'b1;
      if (!ena_3v3_n) begin
        n3++; if (first3 < 0) first3 = cyc; last3 = cyc;
        if (phase != 2'd1) phase_bad++;
      end
      if (!ena_1v8_n) begin
        n18++; if (first18 < 0) first18 = cyc; last18 = cyc;
        if (phase != 2'd2) phase_bad++;
      end
      if (pat_oe == 8'hFF) begin
        if (firstoe < 0) firstoe = cyc;
        noe++;
        pats.push_back(pat_out);
        if (phase != 2'd3) phase_bad++;
        if (restart_mid && noe == 3) start = 1'b1;
        if (restart_mid && noe == 8) start = 1'b0;
      end
    end
    start = 1'b0;

    check({tag, "_finished"}, {31'b0, seen_busy && done}, 32'd1);
    check({tag, "_3v3_len"}, n3, DW);
    check({tag, "_3v3_contig"}, last3 - first3 + 1, DW);
    check({tag, "_1v8_len"}, n18, DW);
    check({tag, "_1v8_contig"}, last18 - first18 + 1, DW);
    check({tag, "_gap1"}, first18 - last3 - 1, GP);
    check({tag, "_gap2"}, firstoe - last18 - 1, GP);
    check({tag, "_oe_cycles"}, noe, LEN + SS + 1);
    check({tag, "_phase"}, phase_bad, 0);
    for (int i = 0; i < pats.size(); i++) begin
      want = (i < LEN) ? seq[i] : seq[LEN-1];
      check({tag, "_pat"}, pats[i], want);
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_oe_off"}, pat_oe, 0);
    check({tag, "_err_cnt"}, err_cnt, (exp_errs > 15) ? 15 : exp_errs);
    check({tag, "_pass"}, pass, (exp_errs == 0) ? 1 : 0);
`ifdef FT_ERRCAP_EN
    check({tag, "_err_idx"}, err_idx, exp_idx);
    check({tag, "_err_data"}, err_data, exp_data);
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] s;
    s = 8'h01;
    for (int i = 0; i < LEN; i++) begin
      seq[i] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    clear_corrupt();
    rst_n = 1'b0;
    ena   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_3v3_n", ena_3v3_n, 1);
    check("rst_1v8_n", ena_1v8_n, 1);
    check("rst_pat_out", pat_out, 0);
    check("rst_pat_oe", pat_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_phase", phase, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);

    run_seq("clean", 1'b0);

    and_mask = 8'hF7;
    run_seq("stuck3", 1'b0);
    clear_corrupt();

    xor_by_val[seq[5]] = 8'($urandom_range(1, 255));
    run_seq("single5", 1'b0);
    clear_corrupt();

    for (int i = 0; i < 256; i++) xor_by_val[i] = 8'hFF;
    run_seq("allbad", 1'b0);
    clear_corrupt();

    run_seq("restart", 1'b1);

    // Abort during EN1V8, then relaunch.
    start = 1'b1;
    for (int i = 0; i < 100 && ena_1v8_n; i++) begin
      @(negedge clk);
      if (i == 4) start = 1'b0;
    end
    start = 1'b0;
    check("abort_reach_1v8", ena_1v8_n, 0);
    @(negedge clk);
    ena = 1'b0;
    @(posedge clk);
    #1;
    check("abort_3v3_n", ena_3v3_n, 1);
    check("abort_1v8_n", ena_1v8_n, 1);
    check("abort_busy", busy, 0);
    check("abort_phase", phase, 0);
    check("abort_done", done, 0);
    check("abort_oe", pat_oe, 0);
    @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    run_seq("relaunch", 1'b0);

    for (int r = 0; r < 4; r++) begin
      clear_corrupt();
      for (int i = 0; i < LEN; i++)
        if ($urandom_range(0, 3) == 0) xor_by_val[seq[i]] = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) and_mask = ~(8'h01 << $urandom_range(0, 7));
      run_seq("rand", 1'b0);
    end
    clear_corrupt();

    // Asynchronous reset in the middle of EN3V3.
    start = 1'b1;
    for (int i = 0; i < 100 && ena_3v3_n; i++) @(negedge clk);
    start = 1'b0;
    check("arst_reach_3v3", ena_3v3_n, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_3v3_n", ena_3v3_n, 1);
    check("arst_1v8_n", ena_1v8_n, 1);
    check("arst_busy", busy, 0);
    check("arst_oe", pat_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_phase", phase, 0);
    check("arst_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
